tft_pattern_gen_ahb: RTL and testbench

- AHB-Lite read-only slave that emulates a TFT framebuffer.
- Instead of storing pixels, it generates packed pixel words on demand from the word address, a selectable pattern mode and a frame counter.
- Sits in place of the framebuffer SRAM, so the TFT controller and DMA can be brought up and verified without memory.
- Adds to the previous generation: proper address/data-phase pipelining, pixel packing, multiple patterns, a frame counter, configurable wait states and out-of-range ERROR responses.

---
 rtl/AHB_PKG.sv | 22 ++
 rtl/tft_pattern_gen_ahb_if.sv | 25 ++
 rtl/tft_pattern_gen_ahb.sv | 175 +++++++++++++++++
 tb/tb_tft_pattern_gen_ahb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/AHB_PKG.sv
// AHB-Lite transfer and burst encodings shared by bus masters and slaves.
package AHB_PKG;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_t;

endpackage

// File: rtl/tft_pattern_gen_ahb_if.sv
// AHB-Lite slave-side signal bundle for the TFT pattern generator.
//   master modport: drives HADDR/HBURST/HTRANS/HWRITE/HWDATA, observes HRDATA/HREADY/HRESP
//   slave  modport: the reverse
interface tft_pattern_gen_ahb_if;

  logic [31:0]       HADDR;
  AHB_PKG::burst_t   HBURST;
  AHB_PKG::trans_t   HTRANS;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HBURST, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/tft_pattern_gen_ahb.sv
// Read-only AHB-Lite slave standing in for a TFT framebuffer: pixel words are
// generated from the word address, a pattern mode and a frame counter.
// Ports:
//   HCLK, HRESET  clock, asynchronous active-high reset
//   bus           AHB-Lite slave bundle (HRDATA/HREADY/HRESP registered)
//   MODE          pattern select, latched in the address phase
//   COLOUR        solid-fill pixel value (low PIXEL_WIDTH bits)
//   FRAME         frame counter, bumps after the last word of a frame is read
module tft_pattern_gen_ahb #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CHECK_SHIFT = 3
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  tft_pattern_gen_ahb_if.slave        bus,
  input  logic [1:0]                  MODE,
  input  logic [31:0]                 COLOUR,
  output logic [7:0]                  FRAME
);

  import AHB_PKG::*;

  localparam int unsigned PPW         = 32 / PIXEL_WIDTH;
  localparam int unsigned FRAME_WORDS = WIDTH * HEIGHT / PPW;
  localparam logic [31:0] LAST_WORD   = 32'(FRAME_WORDS - 1);
  localparam logic [3:0]  WAIT_LAST   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] w_q, w_d;
  logic        wr_q, wr_d;
  logic [1:0]  mode_q, mode_d;
  logic        oor_q, oor_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic        hready_q, hready_d;
  logic        hresp_q, hresp_d;
  logic [7:0]  frame_q, frame_d;

  logic        accept;
  logic [31:0] w_live;
  logic        oor_live;
  logic [31:0] gen_w;
  logic [1:0]  gen_mode;
  logic [31:0] pix_word;
  logic        unused_ok;

  // Pack PPW generated pixels for word index w, pixel 0 in the LSBs.
  function automatic logic [31:0] gen_word(input logic [31:0] w,
                                           input logic [1:0]  mode,
                                           input logic [7:0]  frame,
                                           input logic [PIXEL_WIDTH-1:0] colour);
    logic [31:0] word, p, x, y, chk;
    word = '0;
    for (int k = 0; k < int'(PPW); k++) begin
      p   = w * 32'(PPW) + 32'(k);
      x   = p % 32'(WIDTH);
      y   = p / 32'(WIDTH);
      chk = (x >> CHECK_SHIFT) ^ (y >> CHECK_SHIFT);
      case (mode)
        2'd1:    word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = chk[0] ? {PIXEL_WIDTH{1'b1}} : '0;
        2'd2:    word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(x + 32'(frame));
        default: word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = colour;
      endcase
    end
    if (mode == 2'd0) word = w;
    return word;
  endfunction

  assign accept   = hready_q && (bus.HTRANS == TRANS_NONSEQ || bus.HTRANS == TRANS_SEQ);
  assign w_live   = (bus.HADDR - BASE_ADDR) >> 2;
  assign oor_live = (bus.HADDR < BASE_ADDR) || (w_live >= 32'(FRAME_WORDS));

  // One generator shared by the zero-wait path (live address) and the end of WAIT (latched).
  assign gen_w    = (state_q == S_WAIT) ? w_q : w_live;
  assign gen_mode = (state_q == S_WAIT) ? mode_q : MODE;
  assign pix_word = gen_word(gen_w, gen_mode, frame_q, COLOUR[PIXEL_WIDTH-1:0]);

  assign unused_ok = ^{bus.HBURST, bus.HWDATA, COLOUR};

  // State and registered outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      w_q      <= '0;
      wr_q     <= 1'b0;
      mode_q   <= '0;
      oor_q    <= 1'b0;
      hrdata_q <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      w_q      <= w_d;
      wr_q     <= wr_d;
      mode_q   <= mode_d;
      oor_q    <= oor_d;
      hrdata_q <= hrdata_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      frame_q  <= frame_d;
    end
  end

  // Next state, latched address-phase info and next output values.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    w_d      = w_q;
    wr_d     = wr_q;
    mode_d   = mode_q;
    oor_d    = oor_q;
    hrdata_d = hrdata_q;
    frame_d  = frame_q;

    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          if (oor_q) begin
            state_d  = S_ERR1;
            hrdata_d = '0;
          end else begin
            state_d = S_DATA;
            if (!wr_q) hrdata_d = pix_word;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_DATA: begin
        state_d = S_IDLE;
        if (!wr_q && w_q == LAST_WORD) frame_d = frame_q + 8'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new address phase overrides the return to IDLE (back-to-back pipelining).
    if (accept) begin
      w_d    = w_live;
      wr_d   = bus.HWRITE;
      mode_d = MODE;
      oor_d  = oor_live;
      wcnt_d = '0;
      if (WAIT_STATES != 0) begin
        state_d = S_WAIT;
      end else if (oor_live) begin
        state_d  = S_ERR1;
        hrdata_d = '0;
      end else begin
        state_d = S_DATA;
        if (!bus.HWRITE) hrdata_d = pix_word;
      end
    end

    hready_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_ERR2);
    hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  assign bus.HRDATA = hrdata_q;
  assign bus.HREADY = hready_q;
  assign bus.HRESP  = hresp_q;
  assign FRAME      = frame_q;

endmodule

// File: tb/tb_tft_pattern_gen_ahb.sv
// Self-checking bench for tft_pattern_gen_ahb: a zero-wait and a two-wait-state
// instance share one pipelined AHB master; a transaction-level model predicts
// every response cycle, read word and frame count.
module tb_tft_pattern_gen_ahb;

  import AHB_PKG::*;

  localparam logic [31:0] BASE     = 32'h1000;
  localparam int unsigned WPIX     = 4;
  localparam int unsigned WORDS    = 4;
  localparam int unsigned CS       = 0;
  localparam logic [31:0] COLOUR_V = 32'hABCD1234;
  localparam int          LIMIT    = 4000;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [1:0]  mode;
    trans_t      trans;
    burst_t      burst;
    int          gap;
  } txn_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  bit          sel;
  logic [31:0] t_addr;
  trans_t      t_trans;
  burst_t      t_burst;
  logic        t_write;
  logic [1:0]  t_mode;
  logic [7:0]  frame0, frame1;
  logic        m_ready, m_resp;
  logic [31:0] m_rdata;
  logic [7:0]  m_frame;

  int          n_checks = 0;
  int          n_errors = 0;
  txn_t        txq[$];
  logic [7:0]  frame_m [2];
  logic [31:0] rdata_m [2];
  logic [31:0] last_obs;

  always #5 HCLK = ~HCLK;

  tft_pattern_gen_ahb_if bus0 ();
  tft_pattern_gen_ahb_if bus1 ();

  assign bus0.HADDR  = t_addr;
  assign bus0.HBURST = t_burst;
  assign bus0.HTRANS = (sel == 1'b0) ? t_trans : TRANS_IDLE;
  assign bus0.HWRITE = t_write;
  assign bus0.HWDATA = 32'h5A5A5A5A;
  assign bus1.HADDR  = t_addr;
  assign bus1.HBURST = t_burst;
  assign bus1.HTRANS = (sel == 1'b1) ? t_trans : TRANS_IDLE;
  assign bus1.HWRITE = t_write;
  assign bus1.HWDATA = 32'hA5A5A5A5;

  assign m_ready = sel ? bus1.HREADY : bus0.HREADY;
  assign m_resp  = sel ? bus1.HRESP  : bus0.HRESP;
  assign m_rdata = sel ? bus1.HRDATA : bus0.HRDATA;
  assign m_frame = sel ? frame1 : frame0;

  tft_pattern_gen_ahb #(.BASE_ADDR(BASE), .WIDTH(4), .HEIGHT(2), .PIXEL_WIDTH(16),
                        .WAIT_STATES(0), .CHECK_SHIFT(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus0), .MODE(t_mode), .COLOUR(COLOUR_V), .FRAME(frame0));

  tft_pattern_gen_ahb #(.BASE_ADDR(BASE), .WIDTH(4), .HEIGHT(2), .PIXEL_WIDTH(16),
                        .WAIT_STATES(2), .CHECK_SHIFT(0)) dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus1), .MODE(t_mode), .COLOUR(COLOUR_V), .FRAME(frame1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h (dut%0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  function automatic bit ref_oor(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= 32'(WORDS));
  endfunction

  // Expected word straight from the pattern definitions, 16-bit pixels, two per word.
  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [1:0] md,
                                           input logic [7:0] fr);
    int unsigned wi, p, x, y, pix;
    logic [31:0] r;
    wi = (a - BASE) >> 2;
    if (md == 2'd0) return wi;
    r = 0;
    for (int k = 0; k < 2; k++) begin
      p = wi * 2 + 32'(k);
      y = p / WPIX;
      x = p - y * WPIX;
      case (md)
        2'd1:    pix = ((((x >> CS) + (y >> CS)) % 2) == 1) ? 32'hFFFF : 32'h0;
        2'd2:    pix = (x + 32'(fr)) % 65536;
        default: pix = COLOUR_V % 65536;
      endcase
      r = r | (pix << (16 * k));
    end
    return r;
  endfunction

  task automatic present(input int idx, input int gap);
    if (idx < txq.size() && gap == 0) begin
      t_addr  = txq[idx].addr;
      t_trans = txq[idx].trans;
      t_burst = txq[idx].burst;
      t_write = txq[idx].write;
      t_mode  = txq[idx].mode;
    end else begin
      t_addr  = $urandom;
      t_trans = trans_t'($urandom_range(0, 1));
      t_burst = BURST_SINGLE;
      t_write = 1'($urandom_range(0, 1));
      t_mode  = 2'($urandom_range(0, 3));
    end
  endtask

  // Drive txq as a pipelined master on the selected instance and check every cycle.
  task automatic run_seq(output int cycles);
    int          idx, gap, pos, budget, cyc, start_cyc, ws, dp_len;
    bit          dp_v, dp_oor, ready_exp, resp_exp, active;
    txn_t        dp;
    logic [7:0]  dp_frame, old_frame;
    logic [31:0] exp_data;
    ws = sel ? 2 : 0;
    idx = 0; pos = 0; budget = 0; cyc = 0; start_cyc = -1; cycles = 0;
    dp_v = 1'b0; dp_oor = 1'b0; dp_frame = '0;
    gap = (txq.size() > 0) ? txq[0].gap : 0;
    @(posedge HCLK);
    #1 present(idx, gap);
    while ((idx < txq.size() || dp_v) && budget < LIMIT) begin
      @(negedge HCLK);
      budget++;
      ready_exp = 1'b1;
      resp_exp  = 1'b0;
      if (dp_v) begin
        dp_len    = ws + (dp_oor ? 2 : 1);
        ready_exp = (pos == dp_len - 1);
        resp_exp  = dp_oor && (pos >= ws);
        if (dp_oor && pos >= ws) begin
          check_eq("err_rdata", m_rdata, 32'h0);
        end else if (ready_exp) begin
          exp_data = dp.write ? rdata_m[sel] : ref_word(dp.addr, dp.mode, dp_frame);
          check_eq(dp.write ? "wr_hold" : "rd_data", m_rdata, exp_data);
        end
        if (ready_exp) last_obs = m_rdata;
      end
      check_eq("hready", 32'(m_ready), 32'(ready_exp));
      check_eq("hresp", 32'(m_resp), 32'(resp_exp));
      check_eq("frame", 32'(m_frame), 32'(frame_m[sel]));
      @(posedge HCLK);
      cyc++;
      if (ready_exp) begin
        old_frame = frame_m[sel];
        if (dp_v) begin
          if (dp_oor) begin
            rdata_m[sel] = '0;
          end else if (!dp.write) begin
            rdata_m[sel] = ref_word(dp.addr, dp.mode, dp_frame);
            if (((dp.addr - BASE) >> 2) == 32'(WORDS - 1)) frame_m[sel] = frame_m[sel] + 8'd1;
          end
          dp_v = 1'b0;
          if (idx == txq.size()) cycles = cyc - start_cyc;
        end
        active = (idx < txq.size()) && (gap == 0);
        if (active) begin
          dp       = txq[idx];
          dp_v     = 1'b1;
          pos      = 0;
          dp_oor   = ref_oor(dp.addr);
          dp_frame = (ws == 0) ? old_frame : frame_m[sel];
          if (start_cyc < 0) start_cyc = cyc;
          idx++;
          gap = (idx < txq.size()) ? txq[idx].gap : 0;
        end else if (gap > 0) begin
          gap--;
        end
      end else begin
        pos++;
      end
      #1 present(idx, gap);
    end
    check_eq("seq_timeout", 32'(budget >= LIMIT), 32'h0);
  endtask

  task automatic push(input logic [31:0] a, input logic wr, input logic [1:0] md,
                      input trans_t tr, input burst_t bu, input int gp);
    txn_t t;
    t.addr = a; t.write = wr; t.mode = md; t.trans = tr; t.burst = bu; t.gap = gp;
    txq.push_back(t);
  endtask

  task automatic single(input logic [31:0] a, input logic wr, input logic [1:0] md);
    int c;
    txq.delete();
    push(a, wr, md, TRANS_NONSEQ, BURST_SINGLE, 0);
    run_seq(c);
  endtask

  task automatic rand_fill(input int n);
    logic [31:0] a;
    txq.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        a = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 3))
          0:       a = BASE - 32'($urandom_range(1, 64));
          1:       a = BASE + 32'h10 + 32'(4 * $urandom_range(0, 20));
          2:       a = 32'hFFFFFFFC;
          default: a = 32'h0;
        endcase
      end
      push(a, 1'($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1) ? TRANS_NONSEQ : TRANS_SEQ,
           burst_t'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end
  endtask

  task automatic model_reset();
    frame_m[0] = '0; frame_m[1] = '0;
    rdata_m[0] = '0; rdata_m[1] = '0;
  endtask

  initial begin
    int c;
    HRESET  = 1'b1;
    sel     = 1'b0;
    t_addr  = '0;
    t_trans = TRANS_IDLE;
    t_burst = BURST_SINGLE;
    t_write = 1'b0;
    t_mode  = 2'd0;
    last_obs = '0;
    model_reset();

    // Reset values on both instances.
    @(negedge HCLK);
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      #1;
      check_eq("rst_hready", 32'(m_ready), 32'h1);
      check_eq("rst_hresp", 32'(m_resp), 32'h0);
      check_eq("rst_hrdata", m_rdata, 32'h0);
      check_eq("rst_frame", 32'(m_frame), 32'h0);
    end
    sel = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;

    // Directed zero-wait reads, errors and a write.
    single(32'h1008, 1'b0, 2'd0); check_eq("m0_1008", last_obs, 32'h00000002);
    single(32'h1000, 1'b0, 2'd1); check_eq("m1_1000", last_obs, 32'hFFFF0000);
    single(32'h1008, 1'b0, 2'd1); check_eq("m1_1008", last_obs, 32'h0000FFFF);
    single(32'h1004, 1'b0, 2'd2); check_eq("m2_1004_f0", last_obs, 32'h00030002);
    single(32'h100C, 1'b0, 2'd2);
    @(negedge HCLK); check_eq("frame_after_last", 32'(m_frame), 32'h1);
    single(32'h1004, 1'b0, 2'd2); check_eq("m2_1004_f1", last_obs, 32'h00040003);
    single(32'h100C, 1'b0, 2'd3); check_eq("m3_fill", last_obs, 32'h12341234);
    single(32'h1010, 1'b0, 2'd0); check_eq("oor_high", last_obs, 32'h0);
    single(32'h0FFC, 1'b0, 2'd0); check_eq("oor_low", last_obs, 32'h0);
    @(negedge HCLK); check_eq("frame_after_err", 32'(m_frame), 32'h2);
    single(32'h1004, 1'b1, 2'd1); check_eq("wr_okay_hold", last_obs, 32'h0);
    @(negedge HCLK); check_eq("frame_after_wr", 32'(m_frame), 32'h2);

    // INCR4 burst on the two-wait-state instance.
    sel = 1'b1;
    txq.delete();
    for (int i = 0; i < 4; i++)
      push(BASE + 32'(4 * i), 1'b0, 2'd0, (i == 0) ? TRANS_NONSEQ : TRANS_SEQ, BURST_INCR4, 0);
    run_seq(c);
    check_eq("burst_cycles", 32'(c), 32'd12);
    check_eq("burst_last", last_obs, 32'h3);
    @(negedge HCLK); check_eq("burst_frame", 32'(m_frame), 32'h1);

    // Reset while the wait-state instance is mid-transfer.
    @(posedge HCLK);
    #1;
    t_addr = 32'h1004; t_trans = TRANS_NONSEQ; t_write = 1'b0; t_mode = 2'd1;
    @(posedge HCLK);
    #1 t_trans = TRANS_IDLE;
    @(negedge HCLK);
    check_eq("pre_rst_wait", 32'(m_ready), 32'h0);
    #2 HRESET = 1'b1;
    #1;
    check_eq("mid_rst_hready", 32'(m_ready), 32'h1);
    check_eq("mid_rst_hresp", 32'(m_resp), 32'h0);
    check_eq("mid_rst_hrdata", m_rdata, 32'h0);
    check_eq("mid_rst_frame", 32'(m_frame), 32'h0);
    sel = 1'b0;
    #1;
    check_eq("mid_rst_frame0", 32'(m_frame), 32'h0);
    check_eq("mid_rst_hrdata0", m_rdata, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    model_reset();

    // Randomized pipelined traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d);
      rand_fill(80);
      run_seq(c);
    end

    // Frame counter wrap: back-to-back reads of the last word.
    sel = 1'b0;
    txq.delete();
    for (int i = 0; i < 260; i++) push(32'h100C, 1'b0, 2'd2, TRANS_NONSEQ, BURST_SINGLE, 0);
    push(32'h1000, 1'b0, 2'd2, TRANS_NONSEQ, BURST_SINGLE, 0);
    run_seq(c);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
